// File: rtl/sized_data_memory.sv
// Word-organised data memory with a valid/ready request port and fixed-latency response.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned h/hu/w accesses with resp_err.
module sized_data_memory #(
    parameter int MEM_DEPTH = 16384,
    parameter int LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state;
    logic [31:0]   mem [MEM_DEPTH];
    logic          accept;
    logic          enter_resp;
    logic          wait_done;
    logic          acc_write;
    logic [2:0]    acc_funct3;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [AW-1:0] acc_idx;
    logic          acc_err;
    logic [3:0]    wmask;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the requester keeps its fields stable until then. Responses cannot be back-pressured.
    assign req_ready = !reset && (state == S_IDLE || state == S_RESP);
    assign accept    = req_valid && req_ready;

    generate
        if (LATENCY == 1) begin : g_direct
            // The access edge is the accept edge, so the live request is used directly.
            assign acc_write  = req_write;
            assign acc_funct3 = req_funct3;
            assign acc_addr   = req_addr;
            assign acc_wdata  = req_wdata;
            assign wait_done  = 1'b1;
            assign enter_resp = accept;
        end else begin : g_latched
            localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);
            logic [3:0]  cnt;
            logic        lat_write;
            logic [2:0]  lat_funct3;
            logic [31:0] lat_addr;
            logic [31:0] lat_wdata;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt        <= 4'd0;
                    lat_write  <= 1'b0;
                    lat_funct3 <= 3'd0;
                    lat_addr   <= 32'd0;
                    lat_wdata  <= 32'd0;
                end else if (accept) begin
                    cnt        <= CNT_INIT;
                    lat_write  <= req_write;
                    lat_funct3 <= req_funct3;
                    lat_addr   <= req_addr;
                    lat_wdata  <= req_wdata;
                end else if (state == S_WAIT && cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end
            end

            assign acc_write  = lat_write;
            assign acc_funct3 = lat_funct3;
            assign acc_addr   = lat_addr;
            assign acc_wdata  = lat_wdata;
            assign wait_done  = (cnt == 4'd0);
            assign enter_resp = (state == S_WAIT) && wait_done;
        end
    endgenerate

    // Upper address bits beyond the memory size are dropped, so addresses wrap.
    assign acc_idx = AW'(acc_addr >> 2);

    always_comb begin
        acc_err = 1'b0;
        case (acc_funct3)
            3'b000, 3'b001, 3'b010: acc_err = 1'b0;
            3'b100, 3'b101:         acc_err = acc_write;
            default:                acc_err = 1'b1;
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        if (acc_funct3[1:0] == 2'b01 && acc_addr[0])
            acc_err = 1'b1;
        if (acc_funct3[1:0] == 2'b10 && acc_addr[1:0] != 2'b00)
            acc_err = 1'b1;
`endif
    end

    always_comb begin
        wmask   = 4'b1111;
        wr_data = acc_wdata;
        case (acc_funct3[1:0])
            2'b00: begin
                wmask   = 4'b0001 << acc_addr[1:0];
                wr_data = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                wmask   = acc_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{acc_wdata[15:0]}};
            end
            default: begin
                wmask   = 4'b1111;
                wr_data = acc_wdata;
            end
        endcase
    end

    assign rd_word = mem[acc_idx];
    assign rd_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    assign rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        case (acc_funct3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_data = {24'd0, rd_byte};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = rd_word;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                mem[i] <= 32'd0;
        end else if (enter_resp && acc_write && !acc_err) begin
            for (int l = 0; l < 4; l++)
                if (wmask[l])
                    mem[acc_idx][8*l +: 8] <= wr_data[8*l +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= enter_resp;
            if (enter_resp) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_write || acc_err) ? 32'd0 : load_data;
            end
            case (state)
                S_IDLE, S_RESP: begin
                    if (accept)
                        state <= (LATENCY == 1) ? S_RESP : S_WAIT;
                    else
                        state <= S_IDLE;
                end
                S_WAIT:  if (wait_done) state <= S_RESP;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sized_data_memory.sv
// Bench for sized_data_memory: a LATENCY=1 instance (64 words) and a LATENCY=3 instance
// (16 words) checked against a byte-array reference model.
`timescale 1ns/1ps
module tb_sized_data_memory;
    localparam int DEPTH0 = 64;
    localparam int DEPTH1 = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0]       req_write = '0;
    logic [1:0][2:0]  req_funct3 = '0;
    logic [1:0][31:0] req_addr = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0]       resp_valid;
    logic [1:0][31:0] resp_rdata;
    logic [1:0]       resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mref [2][256];
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    logic        tr_wr[$];
    logic [2:0]  tr_f3[$];
    logic [31:0] tr_addr[$];
    logic [31:0] tr_wd[$];
    logic [31:0] last_rdata;
    logic        last_err;

    always #5 clk = ~clk;

    sized_data_memory #(.MEM_DEPTH(DEPTH0), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    sized_data_memory #(.MEM_DEPTH(DEPTH1), .LATENCY(3)) u_lat3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic void model_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                mref[d][i] = 8'd0;
    endfunction

    // Reference: memory is a flat byte array; an access is a size, a signedness and a byte offset.
    function automatic void model_exec(input int d, input logic wr, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic err);
        int size;
        bit uns;
        int a;
        logic [31:0] val;
        int nbytes = (d == 0) ? DEPTH0 * 4 : DEPTH1 * 4;
        rd = 32'd0;
        err = 1'b0;
        uns = 1'b0;
        size = 4;
        case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: begin size = 1; uns = 1'b1; end
            3'd5: begin size = 2; uns = 1'b1; end
            default: err = 1'b1;
        endcase
        if (wr && uns) err = 1'b1;
        a = int'(addr % 32'(nbytes));
`ifdef DMEM_MISALIGN_TRAP_EN
        if (a % size != 0) err = 1'b1;
`endif
        a = a - (a % size);
        if (err) return;
        if (wr) begin
            for (int i = 0; i < size; i++)
                mref[d][a + i] = wd[8*i +: 8];
        end else begin
            val = 32'd0;
            for (int i = 0; i < size; i++)
                val = val | (32'(mref[d][a + i]) << (8 * i));
            if (!uns && size < 4 && val[8*size - 1])
                val = val | (32'hFFFF_FFFF << (8 * size));
            rd = val;
        end
    endfunction

    task automatic add(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
        tr_wr.push_back(wr);
        tr_f3.push_back(f3);
        tr_addr.push_back(a);
        tr_wd.push_back(wd);
    endtask

    task automatic clear_tr();
        tr_wr.delete();
        tr_f3.delete();
        tr_addr.delete();
        tr_wd.delete();
    endtask

    task automatic drive(input int d, input int i);
        req_valid[d]  = 1'b1;
        req_write[d]  = tr_wr[i];
        req_funct3[d] = tr_f3[i];
        req_addr[d]   = tr_addr[i];
        req_wdata[d]  = tr_wd[i];
    endtask

    // Issues the queued requests with req_valid held high between them and checks each response.
    task automatic run_seq(input int d);
        int n = tr_wr.size();
        int waits;
        logic [31:0] er;
        logic ee;
        @(negedge clk);
        drive(d, 0);
        for (int i = 0; i < n; i++) begin
            waits = 0;
            while (req_ready[d] !== 1'b1 && waits < 20) begin
                @(negedge clk);
                waits++;
            end
            n_checks++;
            if (req_ready[d] !== 1'b1) begin
                $display("FAIL accept_timeout dut%0d req%0d: req_ready=%b required 1", d, i, req_ready[d]);
                n_fail++;
                req_valid[d] = 1'b0;
                clear_tr();
                return;
            end
            @(posedge clk);
            #1;
            model_exec(d, tr_wr[i], tr_f3[i], tr_addr[i], tr_wd[i], er, ee);
            exp_q.push_back(er);
            exp_err_q.push_back(ee);
            if (i + 1 < n) drive(d, i + 1);
            else req_valid[d] = 1'b0;
            for (int k = 1; k <= lat(d); k++) begin
                @(negedge clk);
                n_checks++;
                if (resp_valid[d] !== (k == lat(d))) begin
                    $display("FAIL resp_valid_timing dut%0d req%0d cycle%0d: got %b required %b",
                             d, i, k, resp_valid[d], (k == lat(d)));
                    n_fail++;
                end
                if (k < lat(d)) begin
                    n_checks++;
                    if (req_ready[d] !== 1'b0) begin
                        $display("FAIL ready_in_wait dut%0d req%0d cycle%0d: got %b required 0",
                                 d, i, k, req_ready[d]);
                        n_fail++;
                    end
                end
            end
            er = exp_q.pop_front();
            ee = exp_err_q.pop_front();
            n_checks++;
            if (resp_rdata[d] !== er) begin
                $display("FAIL rdata dut%0d req%0d (wr=%b f3=%0d addr=%h): got %h required %h",
                         d, i, tr_wr[i], tr_f3[i], tr_addr[i], resp_rdata[d], er);
                n_fail++;
            end
            n_checks++;
            if (resp_err[d] !== ee) begin
                $display("FAIL err dut%0d req%0d (wr=%b f3=%0d addr=%h): got %b required %b",
                         d, i, tr_wr[i], tr_f3[i], tr_addr[i], resp_err[d], ee);
                n_fail++;
            end
            last_rdata = resp_rdata[d];
            last_err   = resp_err[d];
        end
        clear_tr();
    endtask

    task automatic check_last(input string name, input logic [31:0] rd, input logic err);
        n_checks++;
        if (last_rdata !== rd || last_err !== err) begin
            $display("FAIL %s: got rdata=%h err=%b required rdata=%h err=%b",
                     name, last_rdata, last_err, rd, err);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0 ||
                resp_rdata[d] !== 32'd0 || resp_err[d] !== 1'b0) begin
                $display("FAIL reset_outputs dut%0d: ready=%b valid=%b rdata=%h err=%b required 0 0 0 0",
                         d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
                n_fail++;
            end
        end
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (req_ready[d] !== 1'b1) begin
                $display("FAIL ready_after_reset dut%0d: got %b required 1", d, req_ready[d]);
                n_fail++;
            end
        end
    endtask

    task automatic test_word();
        add(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        add(1'b0, 3'd2, 32'h10, 32'd0);
        run_seq(0);
        check_last("lw_after_sw", 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_byte();
        add(1'b1, 3'd0, 32'h21, 32'h0000_0080);
        add(1'b0, 3'd2, 32'h20, 32'd0);
        run_seq(0);
        check_last("lw_after_sb", 32'h0000_8000, 1'b0);
        add(1'b0, 3'd0, 32'h21, 32'd0);
        run_seq(0);
        check_last("lb_sign", 32'hFFFF_FF80, 1'b0);
        add(1'b0, 3'd4, 32'h21, 32'd0);
        run_seq(0);
        check_last("lbu_zero", 32'h0000_0080, 1'b0);
    endtask

    task automatic test_half();
        add(1'b1, 3'd1, 32'h32, 32'h0000_F00D);
        add(1'b0, 3'd1, 32'h32, 32'd0);
        run_seq(0);
        check_last("lh_sign", 32'hFFFF_F00D, 1'b0);
        add(1'b0, 3'd5, 32'h32, 32'd0);
        run_seq(0);
        check_last("lhu_zero", 32'h0000_F00D, 1'b0);
        add(1'b0, 3'd2, 32'h30, 32'd0);
        run_seq(0);
        check_last("lw_after_sh", 32'hF00D_0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        add(1'b1, 3'd2, 32'h8, 32'h0BAD_CAFE);
        add(1'b0, 3'd2, 32'h8, 32'd0);
        add(1'b0, 3'd0, 32'hB, 32'd0);
        run_seq(1);
        check_last("lat3_lb", 32'h0000_000B, 1'b0);
    endtask

    task automatic test_misalign();
        add(1'b1, 3'd2, 32'h10, 32'hCAFE_F00D);
        add(1'b0, 3'd2, 32'h13, 32'd0);
        run_seq(0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check_last("lw_misaligned", 32'd0, 1'b1);
`else
        check_last("lw_misaligned", 32'hCAFE_F00D, 1'b0);
`endif
        add(1'b1, 3'd1, 32'h11, 32'h0000_AAAA);
        add(1'b0, 3'd2, 32'h10, 32'd0);
        run_seq(0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check_last("sh_misaligned", 32'hCAFE_F00D, 1'b0);
`else
        check_last("sh_misaligned", 32'hCAFE_AAAA, 1'b0);
`endif
        add(1'b0, 3'd3, 32'h10, 32'd0);
        run_seq(0);
        check_last("funct3_011", 32'd0, 1'b1);
        add(1'b1, 3'd4, 32'h10, 32'h0000_0055);
        add(1'b0, 3'd0, 32'h10, 32'd0);
        run_seq(1);
        check_last("after_illegal_sbu", 32'd0, 1'b0);
    endtask

    task automatic test_random();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                logic [31:0] a;
                a = 32'($urandom_range(0, (d == 0) ? 255 : 63));
                if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FF00);
                add(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
            end
            run_seq(d);
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        req_valid[1]  = 1'b1;
        req_write[1]  = 1'b1;
        req_funct3[1] = 3'd2;
        req_addr[1]   = 32'h4;
        req_wdata[1]  = 32'h1234_5678;
        n_checks++;
        if (req_ready[1] !== 1'b1) begin
            $display("FAIL ready_before_abort: got %b required 1", req_ready[1]);
            n_fail++;
        end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid[1] !== 1'b0) begin
                $display("FAIL aborted_resp cycle%0d: resp_valid=%b required 0", k, resp_valid[1]);
                n_fail++;
            end
        end
        add(1'b0, 3'd2, 32'h4, 32'd0);
        run_seq(1);
        check_last("store_discarded", 32'd0, 1'b0);
    endtask

    task automatic test_alias();
        add(1'b1, 3'd2, 32'h40, 32'hA5A5_5A5A);
        add(1'b0, 3'd2, 32'h0, 32'd0);
        run_seq(1);
        check_last("addr_wrap", 32'hA5A5_5A5A, 1'b0);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_back_to_back();
        test_misalign();
        test_random();
        test_reset_in_wait();
        test_alias();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
